// File: rtl/host_finish_pack_unit.sv
// host_finish_pack_unit: size-replicated MMIO read packing plus sticky per-core finish tracking
// Ports:
//   clk_i, reset_n_i          clock; synchronous active-low reset
//   pack_data_i/size_i/sel_i  source dword, log2 access bytes, byte offset
//   pack_data_o               selected slice replicated across 64 bits (combinational)
//   finish_v_i/core_i/code_i  finish write strobe, target core, return code
//   finish_w_v_o              one-hot finish strobe (combinational)
//   finish_pass_o/fail_o      strobe split by code==0 / code!=0 (combinational)
//   finish_r_o                sticky finished flags (registered)
//   all_finished_o            registered AND of finish_r_o
module host_finish_pack_unit #(
    parameter int num_core_p = 4,
    localparam int lg_num_core_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [63:0]               pack_data_i,
    input  logic [1:0]                pack_size_i,
    input  logic [2:0]                pack_sel_i,
    output logic [63:0]               pack_data_o,
    input  logic                      finish_v_i,
    input  logic [lg_num_core_lp-1:0] finish_core_i,
    input  logic [7:0]                finish_code_i,
    output logic [num_core_p-1:0]     finish_w_v_o,
    output logic [num_core_p-1:0]     finish_pass_o,
    output logic [num_core_p-1:0]     finish_fail_o,
    output logic [num_core_p-1:0]     finish_r_o,
    output logic                      all_finished_o
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] word_s;

    // low sel bits below the access size are dropped so slices stay naturally aligned
    assign byte_s = pack_data_i[{pack_sel_i, 3'b000} +: 8];
    assign half_s = pack_data_i[{pack_sel_i[2:1], 4'b0000} +: 16];
    assign word_s = pack_data_i[{pack_sel_i[2], 5'b00000} +: 32];

    always_comb begin
        pack_data_o = (pack_size_i == 2'd0) ? {8{byte_s}} :
                      (pack_size_i == 2'd1) ? {4{half_s}} :
                      (pack_size_i == 2'd2) ? {2{word_s}} : pack_data_i;
    end

    // indices at or above num_core_p match no bit and decode to zero
    for (genvar g = 0; g < num_core_p; g++) begin : g_dec
        assign finish_w_v_o[g] = finish_v_i && (32'(finish_core_i) == g);
    end

    assign finish_pass_o = (finish_code_i == 8'h00) ? finish_w_v_o : '0;
    assign finish_fail_o = (finish_code_i != 8'h00) ? finish_w_v_o : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            finish_r_o     <= '0;
            all_finished_o <= 1'b0;
        end else begin
            finish_r_o     <= finish_r_o | finish_w_v_o;
            all_finished_o <= &finish_r_o;
        end
    end
endmodule

// File: tb/tb_host_finish_pack_unit.sv
// tb_host_finish_pack_unit: directed self-checking bench for host_finish_pack_unit (4-core and 3-core instances)
module tb_host_finish_pack_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] pack_data;
    logic [1:0]  pack_size;
    logic [2:0]  pack_sel;
    logic        finish_v;
    logic [1:0]  finish_core;
    logic [7:0]  finish_code;

    logic [63:0] pack_out4, pack_out3;
    logic [3:0]  w_v4, pass4, fail4, r4;
    logic [2:0]  w_v3, pass3, fail3, r3;
    logic        all4, all3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    host_finish_pack_unit #(.num_core_p(4)) u4 (
        .clk_i(clk), .reset_n_i(reset_n),
        .pack_data_i(pack_data), .pack_size_i(pack_size), .pack_sel_i(pack_sel),
        .pack_data_o(pack_out4),
        .finish_v_i(finish_v), .finish_core_i(finish_core), .finish_code_i(finish_code),
        .finish_w_v_o(w_v4), .finish_pass_o(pass4), .finish_fail_o(fail4),
        .finish_r_o(r4), .all_finished_o(all4)
    );

    host_finish_pack_unit #(.num_core_p(3)) u3 (
        .clk_i(clk), .reset_n_i(reset_n),
        .pack_data_i(pack_data), .pack_size_i(pack_size), .pack_sel_i(pack_sel),
        .pack_data_o(pack_out3),
        .finish_v_i(finish_v), .finish_core_i(finish_core), .finish_code_i(finish_code),
        .finish_w_v_o(w_v3), .finish_pass_o(pass3), .finish_fail_o(fail3),
        .finish_r_o(r3), .all_finished_o(all3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pk(input logic [1:0] s, input logic [2:0] sel, input logic [63:0] exp, input string tag);
        pack_size = s;
        pack_sel  = sel;
        #1;
        chk(tag, pack_out4, exp);
        chk({tag, "_n3"}, pack_out3, exp);
    endtask

    task automatic fin(input logic v, input logic [1:0] core, input logic [7:0] code);
        finish_v    = v;
        finish_core = core;
        finish_code = code;
    endtask

    initial begin
        reset_n   = 1'b0;
        pack_data = 64'h8877_6655_4433_2211;
        pack_size = 2'd0;
        pack_sel  = 3'd0;
        fin(1'b1, 2'd0, 8'h00);
        #1;
        chk("live_wv_in_reset", 64'(w_v4), 64'h1);
        tick;
        chk("rst1_r", 64'(r4), 64'h0);
        chk("rst1_all", 64'(all4), 64'h0);
        tick;
        chk("rst2_r", 64'(r4), 64'h0);
        chk("rst2_all", 64'(all4), 64'h0);
        chk("rst2_r3", 64'(r3), 64'h0);
        reset_n = 1'b1;
        tick;
        chk("rel_r", 64'(r4), 64'h1);
        chk("rel_r3", 64'(r3), 64'h1);
        chk("rel_all", 64'(all4), 64'h0);
        fin(1'b0, 2'd0, 8'h00);

        pk(2'd0, 3'd5, 64'h6666_6666_6666_6666, "pk_s0_sel5");
        pk(2'd0, 3'd0, 64'h1111_1111_1111_1111, "pk_s0_sel0");
        pk(2'd1, 3'd6, 64'h8877_8877_8877_8877, "pk_s1_sel6");
        pk(2'd1, 3'd1, 64'h2211_2211_2211_2211, "pk_s1_sel1");
        pk(2'd2, 3'd4, 64'h8877_6655_8877_6655, "pk_s2_sel4");
        pk(2'd2, 3'd5, 64'h8877_6655_8877_6655, "pk_s2_sel5");
        pk(2'd2, 3'd3, 64'h4433_2211_4433_2211, "pk_s2_sel3");
        pk(2'd3, 3'd3, 64'h8877_6655_4433_2211, "pk_s3_sel3");
        pack_data = 64'h0123_4567_89ab_cdef;
        pk(2'd0, 3'd7, 64'h0101_0101_0101_0101, "pk2_s0_sel7");
        pk(2'd1, 3'd2, 64'h89ab_89ab_89ab_89ab, "pk2_s1_sel2");

        fin(1'b1, 2'd2, 8'h00);
        #1;
        chk("dec_wv", 64'(w_v4), 64'h4);
        chk("dec_pass", 64'(pass4), 64'h4);
        chk("dec_fail", 64'(fail4), 64'h0);
        fin(1'b1, 2'd2, 8'h03);
        #1;
        chk("dec_code3_wv", 64'(w_v4), 64'h4);
        chk("dec_code3_fail", 64'(fail4), 64'h4);
        chk("dec_code3_pass", 64'(pass4), 64'h0);
        fin(1'b0, 2'd2, 8'h00);
        #1;
        chk("dec_v0_wv", 64'(w_v4), 64'h0);
        chk("dec_v0_pass", 64'(pass4), 64'h0);
        chk("dec_v0_fail", 64'(fail4), 64'h0);

        fin(1'b1, 2'd1, 8'h00);
        tick;
        chk("acc_c1", 64'(r4), 64'h3);
        fin(1'b1, 2'd2, 8'h01);
        tick;
        chk("acc_c2", 64'(r4), 64'h7);
        chk("acc_c2_all", 64'(all4), 64'h0);
        fin(1'b1, 2'd3, 8'h00);
        reset_n = 1'b0;
        tick;
        chk("mid_rst_r", 64'(r4), 64'h0);
        chk("mid_rst_all", 64'(all4), 64'h0);
        chk("mid_rst_r3", 64'(r3), 64'h0);

        reset_n = 1'b1;
        fin(1'b1, 2'd3, 8'h00);
        #1;
        chk("oor_wv3", 64'(w_v3), 64'h0);
        chk("oor_pass3", 64'(pass3), 64'h0);
        chk("oor_fail3", 64'(fail3), 64'h0);
        chk("oor_wv4", 64'(w_v4), 64'h8);
        tick;
        chk("oor_r3", 64'(r3), 64'h0);
        chk("oor_r4", 64'(r4), 64'h8);
        fin(1'b0, 2'd0, 8'h00);
        reset_n = 1'b0;
        tick;
        chk("rst3_r", 64'(r4), 64'h0);
        reset_n = 1'b1;

        fin(1'b1, 2'd0, 8'h00);
        tick;
        chk("seq1_r", 64'(r4), 64'h1);
        chk("seq1_all", 64'(all4), 64'h0);
        fin(1'b0, 2'd0, 8'h00);
        tick;
        chk("seq2_r", 64'(r4), 64'h1);
        fin(1'b1, 2'd1, 8'h00);
        tick;
        chk("seq3_r", 64'(r4), 64'h3);
        fin(1'b1, 2'd1, 8'h05);
        tick;
        chk("seq4_repeat_r", 64'(r4), 64'h3);
        chk("seq4_all", 64'(all4), 64'h0);
        fin(1'b1, 2'd2, 8'h00);
        tick;
        chk("seq5_r", 64'(r4), 64'h7);
        chk("seq5_r3", 64'(r3), 64'h7);
        chk("seq5_all3", 64'(all3), 64'h0);
        fin(1'b0, 2'd0, 8'h00);
        tick;
        chk("seq6_all", 64'(all4), 64'h0);
        chk("seq6_all3", 64'(all3), 64'h1);
        tick;
        chk("seq7_r", 64'(r4), 64'h7);
        chk("seq7_all", 64'(all4), 64'h0);
        fin(1'b1, 2'd3, 8'h7f);
        tick;
        chk("seq8_r", 64'(r4), 64'hf);
        chk("seq8_all_not_yet", 64'(all4), 64'h0);
        fin(1'b0, 2'd0, 8'h00);
        tick;
        chk("seq9_all", 64'(all4), 64'h1);
        tick;
        chk("seq10_all_hold", 64'(all4), 64'h1);
        chk("seq10_r", 64'(r4), 64'hf);
        reset_n = 1'b0;
        tick;
        chk("end_rst_r", 64'(r4), 64'h0);
        chk("end_rst_all", 64'(all4), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/host_finish_pack_unit.md
# host_finish_pack_unit

Host-side MMIO helper for the nonsynthesizable host model. It performs two jobs. First, it formats a 64-bit read dword into a size-replicated response word, the way the bootrom path answers sub-dword reads. Second, it tracks per-core "finish" writes in sticky registers and produces a registered all-cores-finished flag that the host uses to end simulation. It sits between the host command FIFO output and the response mux / termination logic.

## Interface
- `num_core_p`, default 4: number of cores tracked; ≥1.
- `lg_num_core_lp`, derived: safe clog2(`num_core_p`), minimum 1.
- `clk_i` input 1: sole clock; all state updates on the rising edge.
- `reset_n_i` input 1: reset, synchronous and active-low.
- `pack_data_i` input 64: little-endian source dword.
- `pack_size_i` input 2: log2 of access bytes (0=1B, 1=2B, 2=4B, 3=8B).
- `pack_sel_i` input 3: byte offset within the dword (addr[2:0]).
- `pack_data_o` output 64: packed/replicated word; combinational.
- `finish_v_i` input 1: finish write accepted this cycle (command dequeued).
- `finish_core_i` input `lg_num_core_lp`: target core index (addr[3+:lg]).
- `finish_code_i` input 8: return code (data[7:0]).
- `finish_w_v_o` output `num_core_p`: one-hot decoded finish strobe; combinational.
- `finish_pass_o` output `num_core_p`: `finish_w_v_o` masked by code==0.
- `finish_fail_o` output `num_core_p`: `finish_w_v_o` masked by code!=0.
- `finish_r_o` output `num_core_p`: sticky per-core finished flags; registered.
- `all_finished_o` output 1: registered AND of `finish_r_o`.

## Operation
- Pack, for size s:
  - slice width = 8·2^s bits.
  - slice index = `pack_sel_i` >> s; low s bits of sel are ignored, so accesses are treated as naturally aligned.
  - slice = `pack_data_i[index·8·2^s +: 8·2^s]`.
  - `pack_data_o` = slice replicated 64/(8·2^s) times.
  - s=3 passes the data through unchanged; sel is ignored.
- Decode:
  - `finish_w_v_o[i]` = `finish_v_i` && (`finish_core_i` == i).
  - An index ≥ `num_core_p` yields all zeros.
  - With `finish_v_i`=0 the output is all zeros.
- Pass/fail:
  - `finish_pass_o` = `finish_w_v_o` when `finish_code_i`==8'h00, else 0.
  - `finish_fail_o` = `finish_w_v_o` when `finish_code_i`!=0, else 0.
  - Exactly one of the two is nonzero for a valid, in-range finish.
- Accumulator:
  - next `finish_r_o` = `finish_r_o` | `finish_w_v_o`.
  - Bits only set; they never clear except by reset.
  - A repeated finish to the same core has no effect.
- All-finished: next `all_finished_o` = &`finish_r_o` (the current registered value).

## Timing
- Reset: on a rising edge with `reset_n_i`=0, `finish_r_o`←0 and `all_finished_o`←0.
  - Reset wins over a simultaneous finish strobe.
  - Reset applied mid-operation clears all accumulated state.
  - Combinational outputs stay live during reset.
- Finish strobe in cycle N (edge N):
  - `finish_r_o` bit visible in cycle N+1.
  - If that completes the set, `all_finished_o`=1 in cycle N+2.
  - Total latency is 2 cycles.
- `all_finished_o` stays 1 until reset.
- Multiple cores may finish in different cycles in any order; finish codes do not affect the accumulator.
- Pack and decode paths: zero latency, no state.

## Test plan
- Reset: hold `reset_n_i`=0 for 2 cycles with `finish_v_i`=1, core 0 → `finish_r_o`=0, `all_finished_o`=0; after release, `finish_r_o[0]` sets next cycle.
- Pack, data=64'h8877_6655_4433_2211:
  - size0, sel5 → 64'h6666_6666_6666_6666.
  - size1, sel6 → 64'h8877_8877_8877_8877.
  - size2, sel4 → 64'h8877_6655_8877_6655.
  - size2, sel5 (misaligned) → same as sel4.
  - size3, any sel → data unchanged.
- Decode with `num_core_p`=4:
  - core 2, v=1, code 0 → `finish_w_v_o`=4'b0100, pass=4'b0100, fail=0.
  - code 8'h03 → fail=4'b0100, pass=0.
  - v=0 → all zeros.
- Accumulate/latency:
  - finish cores 0,1,2,3 on cycles 1,3,3(repeat 1),5 → `finish_r_o`=4'b1111 at cycle 6, `all_finished_o`=1 at cycle 7 and never earlier.
- Out of range with `num_core_p`=3:
  - `finish_core_i`=3 → no strobe, no state change.
- Mid-run reset:
  - after 4'b0111, assert reset → all state 0; refinishing all four cores is required before `all_finished_o` asserts.
